// File: rtl/sr_sched_pkg.sv
// Shared command encodings and FSM state type for the SR flag scheduler.
package sr_sched_pkg;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_SET = 2'b01;
    localparam logic [1:0] CMD_CLR = 2'b10;
    localparam logic [1:0] CMD_TOG = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_e;

endpackage

// File: rtl/sr_flag_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          grant_en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan candidates in priority order starting at the pointer.
    always_comb begin
        int unsigned cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!any && req[IW'(cand)]) begin
                any = 1'b1;
                idx = IW'(cand);
            end
        end
        if (grant_en && any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sr_flag_sched.sv
// Round-robin scheduler issuing single-cycle S/R pulses to external SR flops.
module sr_flag_sched
    import sr_sched_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned N_FLAG = 6,
    parameter int unsigned AW     = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           REQ_VALID,
    input  logic [2*N_REQ-1:0]         REQ_CMD,
    input  logic [AW*N_REQ-1:0]        REQ_ADDR,
    output logic [N_REQ-1:0]           REQ_READY,
    output logic [N_FLAG-1:0]          S_VEC,
    output logic [N_FLAG-1:0]          R_VEC,
    input  logic [N_FLAG-1:0]          Q_VEC,
    output logic                       DONE,
    output logic [$clog2(N_REQ)-1:0]   DONE_ID,
    output logic                       DONE_Q,
    output logic                       DONE_ERR,
    output logic                       BUSY
);

    localparam int unsigned IW = $clog2(N_REQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [IW-1:0]   id_q, id_d;

    logic            grant_en;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;

    logic            addr_ok;
    logic            q_sel;
    logic [N_FLAG-1:0] flag_oh;

    // Grants only in IDLE and never while reset is asserted.
    assign grant_en  = (state_q == IDLE) && RST;
    assign REQ_READY = grant;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req      (REQ_VALID),
        .ptr      (ptr_q),
        .grant_en (grant_en),
        .grant    (grant),
        .idx      (gnt_idx),
        .any      (gnt_any)
    );

    // State and latched-command registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
        end
    end

    // Next-state: accept one command in IDLE, then DRIVE and SETTLE one cycle each.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (grant_en && gnt_any) begin
                    state_d = DRIVE;
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (gnt_idx == IW'(i)) begin
                            cmd_d  = REQ_CMD[2*i +: 2];
                            addr_d = REQ_ADDR[AW*i +: AW];
                        end
                    end
                end
            end
            DRIVE:   state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode the latched address into a flag select and its current Q.
    always_comb begin
        addr_ok = (32'(addr_q) < N_FLAG);
        flag_oh = '0;
        q_sel   = 1'b0;
        for (int unsigned f = 0; f < N_FLAG; f++) begin
            if (addr_q == AW'(f)) begin
                flag_oh[f] = 1'b1;
                q_sel      = Q_VEC[f];
            end
        end
    end

    // Outputs: at most one S or R bit in DRIVE, completion report in SETTLE.
    always_comb begin
        S_VEC    = '0;
        R_VEC    = '0;
        DONE     = 1'b0;
        DONE_ID  = '0;
        DONE_Q   = 1'b0;
        DONE_ERR = 1'b0;
        BUSY     = (state_q != IDLE);
        case (state_q)
            DRIVE: begin
                if (addr_ok) begin
                    case (cmd_q)
                        CMD_SET: S_VEC = flag_oh;
                        CMD_CLR: R_VEC = flag_oh;
                        CMD_TOG: begin
                            if (q_sel) R_VEC = flag_oh;
                            else       S_VEC = flag_oh;
                        end
                        default: ;
                    endcase
                end
            end
            SETTLE: begin
                DONE     = 1'b1;
                DONE_ID  = id_q;
                DONE_Q   = addr_ok & q_sel;
                DONE_ERR = ~addr_ok;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sr_flag_sched.sv
// Self-checking bench for sr_flag_sched with external SR flop models and a
// transaction-level reference model.
module tb_sr_flag_sched;

    localparam int N_REQ  = 4;
    localparam int N_FLAG = 6;
    localparam int AW     = 3;
    localparam int IW     = 2;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b0;
    logic [N_REQ-1:0]      REQ_VALID;
    logic [2*N_REQ-1:0]    REQ_CMD;
    logic [AW*N_REQ-1:0]   REQ_ADDR;
    logic [N_REQ-1:0]      REQ_READY;
    logic [N_FLAG-1:0]     S_VEC;
    logic [N_FLAG-1:0]     R_VEC;
    logic [N_FLAG-1:0]     Q_VEC;
    logic                  DONE;
    logic [IW-1:0]         DONE_ID;
    logic                  DONE_Q;
    logic                  DONE_ERR;
    logic                  BUSY;

    // Requester-side stimulus state
    logic           v [N_REQ];
    logic [1:0]     c [N_REQ];
    logic [AW-1:0]  a [N_REQ];

    // Reference model state
    int                 m_ptr;
    logic [N_FLAG-1:0]  m_flag;
    int                 mode;
    int                 n_tests = 0;
    int                 n_fail  = 0;

    logic [N_FLAG-1:0]  flop_q;

    always #5 CLK = ~CLK;

    sr_flag_sched dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_CMD   (REQ_CMD),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_READY (REQ_READY),
        .S_VEC     (S_VEC),
        .R_VEC     (R_VEC),
        .Q_VEC     (Q_VEC),
        .DONE      (DONE),
        .DONE_ID   (DONE_ID),
        .DONE_Q    (DONE_Q),
        .DONE_ERR  (DONE_ERR),
        .BUSY      (BUSY)
    );

    // External SR flip-flop bank
    always @(posedge CLK or negedge RST) begin
        if (!RST) flop_q <= '0;
        else      flop_q <= (flop_q | S_VEC) & ~R_VEC;
    end
    assign Q_VEC = flop_q;

    // Pack per-requester arrays onto the flat ports
    always_comb begin
        REQ_VALID = '0;
        REQ_CMD   = '0;
        REQ_ADDR  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            REQ_VALID[i]         = v[i];
            REQ_CMD[2*i +: 2]    = c[i];
            REQ_ADDR[AW*i +: AW] = a[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle-wide invariants
    always @(negedge CLK) begin
        if (RST) begin
            chk("inv_s_and_r", 32'(S_VEC & R_VEC), 32'd0);
            chk("inv_sr_max1", 32'($countones(S_VEC | R_VEC) <= 1), 32'd1);
            chk("inv_ready_1h", 32'($countones(REQ_READY) <= 1), 32'd1);
            chk("inv_ready_idle", 32'((REQ_READY == '0) || !BUSY), 32'd1);
        end
    end

    function automatic int pick();
        int idx;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (m_ptr + k) % N_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic new_cmd(input int i);
        c[i] = 2'($urandom_range(0, 3));
        a[i] = AW'($urandom_range(0, 7));
        v[i] = 1'b1;
    endtask

    task automatic set_req(input int i, input logic vld, input logic [1:0] cm, input logic [AW-1:0] ad);
        v[i] = vld;
        c[i] = cm;
        a[i] = ad;
    endtask

    // One scheduling slot, entered and left at posedge+1 with the DUT in IDLE.
    task automatic txn();
        int g;
        logic [1:0]        cm;
        logic [AW-1:0]     ad;
        logic              inr;
        logic [N_FLAG-1:0] es, er;
        #1;
        g = pick();
        if (g < 0) begin
            chk("idle_ready", 32'(REQ_READY), 32'd0);
            chk("idle_busy", 32'(BUSY), 32'd0);
            @(posedge CLK); #1;
            return;
        end
        chk("ready", 32'(REQ_READY), 32'(1 << g));
        chk("accept_busy", 32'(BUSY), 32'd0);
        chk("accept_done", 32'(DONE), 32'd0);
        cm = c[g];
        ad = a[g];
        @(posedge CLK); #1;
        case (mode)
            0: v[g] = 1'b0;
            1: ;
            default: begin
                if ($urandom_range(0, 3) == 0) v[g] = 1'b0;
                else new_cmd(g);
            end
        endcase
        if (mode == 2) begin
            for (int i = 0; i < N_REQ; i++)
                if (!v[i] && $urandom_range(0, 2) == 0) new_cmd(i);
        end
        m_ptr = (g + 1) % N_REQ;
        #1;
        inr = (int'(ad) < N_FLAG);
        es  = '0;
        er  = '0;
        if (inr) begin
            case (cm)
                2'b01: es[ad] = 1'b1;
                2'b10: er[ad] = 1'b1;
                2'b11: if (m_flag[ad]) er[ad] = 1'b1; else es[ad] = 1'b1;
                default: ;
            endcase
        end
        chk("drive_s", 32'(S_VEC), 32'(es));
        chk("drive_r", 32'(R_VEC), 32'(er));
        chk("drive_busy", 32'(BUSY), 32'd1);
        chk("drive_ready", 32'(REQ_READY), 32'd0);
        chk("drive_done", 32'(DONE), 32'd0);
        m_flag = (m_flag | es) & ~er;
        @(posedge CLK); #2;
        chk("done", 32'(DONE), 32'd1);
        chk("done_id", 32'(DONE_ID), 32'(g));
        chk("done_q", 32'(DONE_Q), 32'(inr ? m_flag[ad] : 1'b0));
        chk("done_err", 32'(DONE_ERR), 32'(!inr));
        chk("settle_sr", 32'(S_VEC | R_VEC), 32'd0);
        chk("settle_ready", 32'(REQ_READY), 32'd0);
        chk("settle_busy", 32'(BUSY), 32'd1);
        @(posedge CLK); #1;
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, 2'b00, '0);
        m_ptr  = 0;
        m_flag = '0;
        mode   = 0;

        // Reset holds every output low even with a valid request present
        repeat (2) @(posedge CLK);
        #1;
        set_req(0, 1'b1, 2'b01, 3'd2);
        #1;
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_s", 32'(S_VEC), 32'd0);
        chk("rst_r", 32'(R_VEC), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;

        // Single SET from requester 0 to flag 2
        txn();

        // Toggle flag 5 twice from requester 1
        set_req(1, 1'b1, 2'b11, 3'd5);
        mode = 1;
        txn();
        mode = 0;
        txn();

        // All four requesters continuously valid with CLR commands
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 2'b10, AW'(i + 1));
        mode = 1;
        repeat (5) txn();
        for (int i = 0; i < N_REQ; i++) v[i] = 1'b0;
        mode = 0;

        // Out-of-range address
        set_req(2, 1'b1, 2'b01, 3'd7);
        txn();

        // NOP reports the unchanged flag value
        set_req(0, 1'b1, 2'b00, 3'd1);
        txn();

        // Empty slot
        txn();

        // Randomized traffic
        mode = 2;
        for (int i = 0; i < N_REQ; i++) if ($urandom_range(0, 1) == 1) new_cmd(i);
        repeat (150) txn();
        for (int i = 0; i < N_REQ; i++) v[i] = 1'b0;
        mode = 0;
        txn();

        // Reset during DRIVE of a SET to flag 0
        m_ptr = m_ptr; // pointer position is whatever the traffic left
        set_req(0, 1'b1, 2'b01, 3'd0);
        #1;
        chk("mid_ready", 32'(REQ_READY), 32'(1 << pick()));
        @(posedge CLK); #1;
        v[0] = 1'b0;
        #1;
        chk("mid_drive_s", 32'(S_VEC), 32'd1);
        RST = 1'b0;
        #1;
        chk("mid_rst_s", 32'(S_VEC), 32'd0);
        chk("mid_rst_r", 32'(R_VEC), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_done", 32'(DONE), 32'd0);
        m_ptr  = 0;
        m_flag = '0;
        repeat (2) begin
            @(posedge CLK); #2;
            chk("mid_no_done", 32'(DONE), 32'd0);
        end
        set_req(3, 1'b1, 2'b01, 3'd4);
        @(posedge CLK); #1;
        RST = 1'b1;
        txn();
        chk("post_rst_ptr", 32'(m_ptr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_flag_sched.md
Name: sr_flag_sched

Overview:
- Schedules set/clear/toggle commands from N_REQ requesters onto a bank of N_FLAG external SR flip-flops.
- Each flag flop has S, R, CLK, RST inputs and a Q output.
- Arbitrates requesters round-robin and drives exactly one flag per command with a single-cycle S or R pulse.
- Never drives S=R=1 on any flop. Reports completion with the resulting Q.

Parameters:
- N_REQ, 4, number of requesters.
- N_FLAG, 6, number of SR flip-flops controlled. Deliberately not a power of two, so out-of-range addresses are exercisable.
- AW, 3, flag address width; must satisfy 2**AW >= N_FLAG.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ_VALID  in  N_REQ  per-requester command valid.
- REQ_CMD  in  2*N_REQ  per-requester command, requester i at bits [2i+1:2i]: 00 NOP, 01 SET, 10 CLR, 11 TOG.
- REQ_ADDR  in  AW*N_REQ  per-requester target flag index.
- REQ_READY  out  N_REQ  one-hot accept pulse.
- S_VEC  out  N_FLAG  S inputs of the flag flops.
- R_VEC  out  N_FLAG  R inputs of the flag flops.
- Q_VEC  in  N_FLAG  Q outputs of the flag flops.
- DONE  out  1  completion pulse.
- DONE_ID  out  2  index of the completed requester; width is clog2(N_REQ).
- DONE_Q  out  1  flag value after the command.
- DONE_ERR  out  1  address was out of range (>= N_FLAG).
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE and the round-robin pointer to 0.
  - All outputs are 0 immediately; S_VEC and R_VEC drop without waiting for a clock.
  - A command in flight is abandoned, with no DONE.
- FSM states: IDLE, DRIVE, SETTLE.
- IDLE:
  - If any REQ_VALID is set, grant the first valid requester at or after the pointer, wrapping modulo N_REQ.
  - REQ_READY[g]=1 combinationally in that same cycle. The handshake completes on that edge.
  - Latch the command, address and g. Pointer becomes (g+1) mod N_REQ. Next state is DRIVE.
  - If no requester is valid, stay in IDLE; the pointer is unchanged.
- DRIVE (exactly one cycle):
  - SET: S_VEC[addr]=1.
  - CLR: R_VEC[addr]=1.
  - TOG: S_VEC[addr]=1 if Q_VEC[addr]=0, else R_VEC[addr]=1. Q_VEC is sampled combinationally in DRIVE.
  - NOP or out-of-range address: nothing is driven.
  - Next state is SETTLE.
- SETTLE (one cycle):
  - DONE=1, DONE_ID=g.
  - DONE_Q = Q_VEC[addr] as seen in this cycle, i.e. after the flop captured the pulse. DONE_Q=0 when the address is out of range.
  - DONE_ERR=1 iff addr >= N_FLAG.
  - Next state is IDLE.
- Timing:
  - Fixed latency of accept edge + 2 cycles to DONE.
  - Throughput is one command per 3 cycles.
  - A new grant can occur in the IDLE cycle immediately after SETTLE.
- Invariants, which hold in every cycle:
  - (S_VEC & R_VEC) == 0.
  - popcount(S_VEC | R_VEC) <= 1, and only in DRIVE.
  - REQ_READY is one-hot or zero, and only in IDLE.
- Requester rules:
  - A requester holds VALID, CMD and ADDR stable until READY.
  - Changes to REQ_* from a non-granted requester while BUSY are ignored.
  - A requester may re-request immediately after its READY. Round-robin still serves the other pending requesters first.
- Same-flag commands: two back-to-back commands to the same flag are serialized naturally. The second one observes the updated Q.

Decomposition:
- Shared package sr_sched_pkg:
  - CMD_NOP, CMD_SET, CMD_CLR, CMD_TOG 2-bit constants.
  - State enum {IDLE, DRIVE, SETTLE}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], pointer, grant_en.
  - Outputs: one-hot grant[N], grant index, any.
  - Purely combinational; the pointer register stays in sr_flag_sched.
- The SR flip-flops themselves live outside this block. The bench instantiates N_FLAG of them, driven from S_VEC/R_VEC.

Test Plan:
- Reset then a single SET: RST low→high; req0 SET addr 2.
  - READY[0] at cycle 0, S_VEC=000100 in cycle 1.
  - DONE in cycle 2 with DONE_ID=0, DONE_Q=1, DONE_ERR=0.
- Toggle pair: req1 TOG addr 5 twice on flag initially 0.
  - First DONE_Q=1 via S_VEC[5], second DONE_Q=0 via R_VEC[5].
  - R_VEC[5] and S_VEC[5] are never both high.
- Round-robin fairness: all 4 valid continuously with CLR commands.
  - Grant order 0,1,2,3,0; READY pulses spaced exactly 3 cycles apart.
- Out-of-range address: req2 SET addr 7.
  - No S/R bit asserted.
  - DONE with DONE_ERR=1, DONE_Q=0, DONE_ID=2.
- Reset mid-operation: RST low during DRIVE of a SET to addr 0.
  - S_VEC=0 within the same cycle; no DONE; BUSY=0.
  - After release, a req3 grant happens first if the pointer is 0 and only req3 is valid.
- NOP: req0 NOP addr 1.
  - No S/R activity; DONE reports DONE_Q equal to the prior Q_VEC[1].
